// File: rtl/nubus_cpu_bridge_if.sv
// rtl/nubus_cpu_bridge_if.sv - processor request / NuBus master handshake bundle for nubus_cpu_bridge
// master drives requests and NuBus acknowledges; slave is the bridge itself.
interface nubus_cpu_bridge_if;
  logic        prc_valid;
  logic [31:0] prc_addr;
  logic [31:0] prc_wdata;
  logic [3:0]  prc_wstrb;
  logic        prc_lock;
  logic        prc_ready;
  logic [31:0] prc_rdata;
  logic        prc_err;

  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_write;
  logic        cpu_lock;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;

  modport master (
    output prc_valid, prc_addr, prc_wdata, prc_wstrb, prc_lock,
    output cpu_ready, cpu_rdata,
    input  prc_ready, prc_rdata, prc_err,
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_write, cpu_lock
  );

  modport slave (
    input  prc_valid, prc_addr, prc_wdata, prc_wstrb, prc_lock,
    input  cpu_ready, cpu_rdata,
    output prc_ready, prc_rdata, prc_err,
    output cpu_valid, cpu_addr, cpu_wdata, cpu_write, cpu_lock
  );
endinterface

// File: rtl/nubus_cpu_bridge.sv
// rtl/nubus_cpu_bridge.sv - single-outstanding processor-to-NuBus request bridge
// Optional request timeout enabled by defining NUBUS_BRIDGE_TIMEOUT_EN.
module nubus_cpu_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               nub_clkn,
  input  logic               nub_resetn,
  nubus_cpu_bridge_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("nubus_cpu_bridge: TIMEOUT_CYCLES out of range 1..255");
  end

  // NuBus state advances on the falling edge of the bus clock.
  logic nub_clk;
  assign nub_clk = ~nub_clkn;

  logic [1:0] state;

`ifdef NUBUS_BRIDGE_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

  logic [7:0] tmo_cnt;
  logic [8:0] tmo_inc;
  logic       tmo_hit;
  logic       err_q;

  assign tmo_inc     = {1'b0, tmo_cnt} + 9'd1;
  assign tmo_hit     = (tmo_inc >= TIMEOUT_LIMIT);
  assign bus.prc_err = err_q;
`else
  assign bus.prc_err = 1'b0;
`endif

  always_ff @(posedge nub_clk or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state         <= ST_IDLE;
      bus.cpu_valid <= 1'b0;
      bus.cpu_addr  <= 32'h0;
      bus.cpu_wdata <= 32'h0;
      bus.cpu_write <= 4'h0;
      bus.cpu_lock  <= 1'b0;
      bus.prc_ready <= 1'b0;
      bus.prc_rdata <= 32'h0;
`ifdef NUBUS_BRIDGE_TIMEOUT_EN
      tmo_cnt       <= 8'h0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          bus.prc_ready <= 1'b0;
          if (bus.prc_valid) begin
            bus.cpu_addr  <= bus.prc_addr;
            bus.cpu_wdata <= bus.prc_wdata;
            bus.cpu_write <= bus.prc_wstrb;
            bus.cpu_lock  <= bus.prc_lock;
            bus.cpu_valid <= 1'b1;
            state         <= ST_REQ;
`ifdef NUBUS_BRIDGE_TIMEOUT_EN
            tmo_cnt       <= 8'h0;
`endif
          end
        end
        ST_REQ: begin
          // An acknowledge on the timeout edge still counts as a completion.
          if (bus.cpu_ready) begin
            bus.prc_rdata <= bus.cpu_rdata;
            bus.cpu_valid <= 1'b0;
            bus.prc_ready <= 1'b1;
            state         <= ST_RESP;
`ifdef NUBUS_BRIDGE_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
          end
`ifdef NUBUS_BRIDGE_TIMEOUT_EN
          else begin
            if (tmo_cnt != 8'hFF) begin
              tmo_cnt <= tmo_inc[7:0];
            end
            if (tmo_hit) begin
              bus.prc_rdata <= 32'hFFFF_FFFF;
              bus.cpu_valid <= 1'b0;
              bus.prc_ready <= 1'b1;
              err_q         <= 1'b1;
              state         <= ST_RESP;
            end
          end
`endif
        end
        ST_RESP: begin
          // One dead cycle here gives the bus its turnaround before the next request.
          bus.prc_ready <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          bus.cpu_valid <= 1'b0;
          bus.prc_ready <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_cpu_bridge.sv
// tb/tb_nubus_cpu_bridge.sv - directed self-checking bench for nubus_cpu_bridge
// Inputs are driven and outputs sampled on the rising edge of nub_clkn, away from the active edge.
module tb_nubus_cpu_bridge;

  logic nub_clkn;
  logic nub_resetn;
  int   checks;
  int   fails;

  nubus_cpu_bridge_if bus ();

  nubus_cpu_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .nub_clkn   (nub_clkn),
    .nub_resetn (nub_resetn),
    .bus        (bus.slave)
  );

  initial nub_clkn = 1'b1;
  always #5 nub_clkn = ~nub_clkn;

  task automatic tick();
    @(posedge nub_clkn);
  endtask

  task automatic test_reset();
    nub_resetn = 1'b0;
    bus.prc_valid = 1'b0; bus.prc_addr = 32'h0; bus.prc_wdata = 32'h0;
    bus.prc_wstrb = 4'h0; bus.prc_lock = 1'b0;
    bus.cpu_ready = 1'b0; bus.cpu_rdata = 32'h0;
    tick(); tick();
    checks++;
    if ({bus.cpu_valid, bus.prc_ready, bus.prc_err, bus.cpu_lock, bus.cpu_write} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.cpu_valid, bus.prc_ready, bus.prc_err, bus.cpu_lock, bus.cpu_write});
    end
    checks++;
    if ({bus.cpu_addr, bus.cpu_wdata, bus.prc_rdata} !== 96'h0) begin
      fails++;
      $display("FAIL reset_data got=%h exp=0", {bus.cpu_addr, bus.cpu_wdata, bus.prc_rdata});
    end
    nub_resetn = 1'b1;
  endtask

  // Started at the tick where reset is released: the first edge must accept it.
  task automatic test_read();
    bus.prc_valid = 1'b1; bus.prc_addr = 32'hF900_0010; bus.prc_wdata = 32'h0;
    bus.prc_wstrb = 4'h0; bus.prc_lock = 1'b0;
    checks++;
    if (bus.cpu_valid !== 1'b0) begin fails++; $display("FAIL read_pre_valid got=%b exp=0", bus.cpu_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.cpu_valid !== 1'b1) begin fails++; $display("FAIL read_cpu_valid[%0d] got=%b exp=1", i, bus.cpu_valid); end
      checks++;
      if (bus.prc_ready !== 1'b0) begin fails++; $display("FAIL read_early_ready[%0d] got=%b exp=0", i, bus.prc_ready); end
      if (i == 0) begin
        checks++;
        if (bus.cpu_addr !== 32'hF900_0010 || bus.cpu_write !== 4'h0) begin
          fails++; $display("FAIL read_latch got=%h/%h exp=F9000010/0", bus.cpu_addr, bus.cpu_write);
        end
      end
      if (i == 2) begin bus.cpu_ready = 1'b1; bus.cpu_rdata = 32'h1234_5678; end
    end
    tick();
    bus.cpu_ready = 1'b0;
    checks++;
    if (bus.prc_ready !== 1'b1 || bus.cpu_valid !== 1'b0) begin
      fails++; $display("FAIL read_complete got ready=%b valid=%b exp 1/0", bus.prc_ready, bus.cpu_valid);
    end
    checks++;
    if (bus.prc_rdata !== 32'h1234_5678 || bus.prc_err !== 1'b0) begin
      fails++; $display("FAIL read_data got=%h err=%b exp=12345678/0", bus.prc_rdata, bus.prc_err);
    end
    bus.prc_valid = 1'b0;
    tick();
    checks++;
    if (bus.prc_ready !== 1'b0 || bus.cpu_valid !== 1'b0) begin
      fails++; $display("FAIL read_after got ready=%b valid=%b exp 0/0", bus.prc_ready, bus.cpu_valid);
    end
    tick();
  endtask

  task automatic test_write();
    int pulses;
    bus.prc_valid = 1'b1; bus.prc_addr = 32'hF900_0020; bus.prc_wdata = 32'hDEAD_BEEF;
    bus.prc_wstrb = 4'hF; bus.prc_lock = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.cpu_valid !== 1'b1 || bus.cpu_write !== 4'hF || bus.cpu_wdata !== 32'hDEAD_BEEF || bus.cpu_addr !== 32'hF900_0020) begin
        fails++;
        $display("FAIL write_req[%0d] got v=%b w=%h d=%h a=%h exp 1/F/DEADBEEF/F9000020", i, bus.cpu_valid, bus.cpu_write, bus.cpu_wdata, bus.cpu_addr);
      end
      if (i == 1) begin bus.cpu_ready = 1'b1; bus.cpu_rdata = 32'hA5A5_A5A5; end
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        bus.cpu_ready = 1'b0; bus.prc_valid = 1'b0;
        checks++;
        if (bus.prc_rdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL write_rdata got=%h exp=A5A5A5A5", bus.prc_rdata); end
      end
      if (bus.prc_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin fails++; $display("FAIL write_pulses got=%0d exp=1", pulses); end
    checks++;
    if (bus.cpu_wdata !== 32'hDEAD_BEEF || bus.cpu_write !== 4'hF) begin
      fails++; $display("FAIL write_hold got=%h/%h exp=DEADBEEF/F", bus.cpu_wdata, bus.cpu_write);
    end
  endtask

  task automatic test_lock();
    bus.prc_valid = 1'b1; bus.prc_addr = 32'h0000_1000; bus.prc_wstrb = 4'h0; bus.prc_lock = 1'b1;
    tick();
    checks++;
    if (bus.cpu_lock !== 1'b1) begin fails++; $display("FAIL lock_set got=%b exp=1", bus.cpu_lock); end
    bus.cpu_ready = 1'b1; bus.cpu_rdata = 32'h0;
    tick();
    bus.cpu_ready = 1'b0; bus.prc_valid = 1'b0;
    tick(); tick();
    checks++;
    if (bus.cpu_lock !== 1'b1 || bus.cpu_valid !== 1'b0) begin
      fails++; $display("FAIL lock_hold_idle got lock=%b valid=%b exp 1/0", bus.cpu_lock, bus.cpu_valid);
    end
    bus.prc_valid = 1'b1; bus.prc_lock = 1'b0;
    tick();
    checks++;
    if (bus.cpu_lock !== 1'b0) begin fails++; $display("FAIL lock_clear got=%b exp=0", bus.cpu_lock); end
    bus.cpu_ready = 1'b1;
    tick();
    bus.cpu_ready = 1'b0; bus.prc_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
`ifdef NUBUS_BRIDGE_TIMEOUT_EN
    bus.prc_valid = 1'b1; bus.prc_addr = 32'h0000_2000; bus.prc_wstrb = 4'h0; bus.prc_lock = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.cpu_valid !== 1'b1 || bus.prc_ready !== 1'b0) begin
        fails++; $display("FAIL tmo_wait[%0d] got valid=%b ready=%b exp 1/0", i, bus.cpu_valid, bus.prc_ready);
      end
    end
    tick();
    checks++;
    if (bus.prc_ready !== 1'b1 || bus.prc_err !== 1'b1 || bus.prc_rdata !== 32'hFFFF_FFFF || bus.cpu_valid !== 1'b0) begin
      fails++;
      $display("FAIL tmo_abort got ready=%b err=%b data=%h valid=%b exp 1/1/FFFFFFFF/0", bus.prc_ready, bus.prc_err, bus.prc_rdata, bus.cpu_valid);
    end
    bus.prc_valid = 1'b0;
    tick();
    checks++;
    if (bus.prc_ready !== 1'b0) begin fails++; $display("FAIL tmo_single got=%b exp=0", bus.prc_ready); end
    tick();
`else
    int bad;
    bus.prc_valid = 1'b1; bus.prc_addr = 32'h0000_2000; bus.prc_wstrb = 4'h0; bus.prc_lock = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.cpu_valid !== 1'b1 || bus.prc_ready !== 1'b0 || bus.prc_err !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL notmo_hold got bad_cycles=%0d exp=0", bad); end
    bus.cpu_ready = 1'b1; bus.cpu_rdata = 32'h0BAD_F00D;
    tick();
    bus.cpu_ready = 1'b0; bus.prc_valid = 1'b0;
    checks++;
    if (bus.prc_ready !== 1'b1 || bus.prc_rdata !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL notmo_complete got ready=%b data=%h exp 1/0BADF00D", bus.prc_ready, bus.prc_rdata);
    end
    tick();
`endif
  endtask

  task automatic test_race();
    bus.prc_valid = 1'b1; bus.prc_addr = 32'h0000_3000; bus.prc_wstrb = 4'h0; bus.prc_lock = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.cpu_valid !== 1'b1) begin fails++; $display("FAIL race_wait[%0d] got=%b exp=1", i, bus.cpu_valid); end
      if (i == 3) begin bus.cpu_ready = 1'b1; bus.cpu_rdata = 32'hCAFE_F00D; end
    end
    tick();
    bus.prc_valid = 1'b0;
    checks++;
    if (bus.prc_ready !== 1'b1 || bus.prc_err !== 1'b0 || bus.prc_rdata !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL race_win got ready=%b err=%b data=%h exp 1/0/CAFEF00D", bus.prc_ready, bus.prc_err, bus.prc_rdata);
    end
    bus.cpu_rdata = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.cpu_valid !== 1'b0 || bus.prc_ready !== 1'b0 || bus.prc_rdata !== 32'hCAFE_F00D) begin
        fails++;
        $display("FAIL stray_ready[%0d] got valid=%b ready=%b data=%h exp 0/0/CAFEF00D", i, bus.cpu_valid, bus.prc_ready, bus.prc_rdata);
      end
    end
    bus.cpu_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic exp_r;
    bus.prc_valid = 1'b1; bus.prc_addr = 32'h0000_5000; bus.prc_wstrb = 4'h0; bus.prc_lock = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_v = (i % 3 == 0);
      exp_r = (i % 3 == 1);
      checks++;
      if (bus.cpu_valid !== exp_v || bus.prc_ready !== exp_r) begin
        fails++; $display("FAIL b2b_seq[%0d] got valid=%b ready=%b exp %b/%b", i, bus.cpu_valid, bus.prc_ready, exp_v, exp_r);
      end
      if (exp_v) begin
        checks++;
        if (bus.cpu_addr !== 32'h0000_5000 + 32'(i / 3)) begin
          fails++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, bus.cpu_addr, 32'h0000_5000 + 32'(i / 3));
        end
      end
      bus.cpu_ready = exp_v;
      if (exp_r) bus.prc_addr = 32'h0000_5000 + 32'(i / 3) + 32'd1;
    end
    bus.prc_valid = 1'b0;
    bus.cpu_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_req();
    logic seen;
    bus.prc_valid = 1'b1; bus.prc_addr = 32'h0000_4000; bus.prc_wdata = 32'h7777_7777;
    bus.prc_wstrb = 4'h3; bus.prc_lock = 1'b1;
    tick(); tick();
    nub_resetn = 1'b0;
    #1;
    checks++;
    if ({bus.cpu_valid, bus.prc_ready, bus.prc_err, bus.cpu_lock, bus.cpu_write} !== 8'h00) begin
      fails++; $display("FAIL rst_mid_ctrl got=%b exp=0", {bus.cpu_valid, bus.prc_ready, bus.prc_err, bus.cpu_lock, bus.cpu_write});
    end
    checks++;
    if ({bus.cpu_addr, bus.cpu_wdata, bus.prc_rdata} !== 96'h0) begin
      fails++; $display("FAIL rst_mid_data got=%h exp=0", {bus.cpu_addr, bus.cpu_wdata, bus.prc_rdata});
    end
    bus.prc_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.prc_ready === 1'b1 || bus.cpu_valid === 1'b1) seen = 1'b1;
    end
    nub_resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.prc_ready === 1'b1 || bus.cpu_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin fails++; $display("FAIL rst_mid_no_resp got=%b exp=0", seen); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_read();
    test_write();
    test_lock();
    test_timeout();
    test_race();
    test_back_to_back();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
